// File: rtl/uart_apb_master.sv
// uart_apb_master
//   Single-outstanding APB3 initiator. A host command (valid/ready) becomes
//   one APB3 SETUP/ACCESS transfer. The result comes back over a valid/ready
//   response channel as read data plus error flags.
//
// Ports
//   i_apb_pclk, i_apb_presetn      : clock, async active-low reset
//   i_cmd_*, o_cmd_ready           : command request (write, byte addr, wdata)
//   o_rsp_*, i_rsp_ready           : response (rdata, err, timeout)
//   o_apb_* / i_apb_*              : APB3 initiator port
//
// Optional feature
//   UART_APB_MASTER_TIMEOUT_EN : aborts ACCESS after TIMEOUT_CYCLES cycles
//   without pready. If this macro is undefined, ACCESS waits forever and
//   o_rsp_timeout is tied to 0.
//
// States
//   ST_IDLE   | ready for a command; APB address/data hold last values
//   ST_SETUP  | psel=1, penable=0 for one cycle
//   ST_ACCESS | psel=1, penable=1 until pready (or timeout)
//   ST_RESP   | o_rsp_valid=1 until the host takes the response
module uart_apb_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_presetn,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
    output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
    output logic                      o_apb_pwrite,
    output logic                      o_apb_psel,
    output logic                      o_apb_penable,
    input  logic                      i_apb_pready,
    input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
    input  logic                      i_apb_pslverr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    // Low address bits that must be zero for a full-word access.
    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'((APB_DATA_WIDTH / 8) - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      misaligned;

`ifdef UART_APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    assign misaligned = |(i_cmd_addr & ALIGN_MASK);

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef UART_APB_MASTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (misaligned) begin
                        // Rejected locally; the APB port never sees it.
                        state_d     = ST_RESP;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
`ifdef UART_APB_MASTER_TIMEOUT_EN
                        rsp_timeout_d = 1'b0;
`endif
                    end else begin
                        state_d  = ST_SETUP;
                        paddr_d  = i_cmd_addr;
                        pwdata_d = i_cmd_wdata;
                        pwrite_d = i_cmd_write;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef UART_APB_MASTER_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                // A pready that arrives on the final allowed cycle still wins.
                if (i_apb_pready) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = (pwrite_q || i_apb_pslverr) ? '0 : i_apb_prdata;
                    rsp_err_d   = i_apb_pslverr;
`ifdef UART_APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_RESP;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Decoding the next state keeps every bus/response strobe a flop output.
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef UART_APB_MASTER_TIMEOUT_EN
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_rsp_timeout = rsp_timeout_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

    assign o_cmd_ready   = (state_q == ST_IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_apb_paddr   = paddr_q;
    assign o_apb_pwdata  = pwdata_q;
    assign o_apb_pwrite  = pwrite_q;
    assign o_apb_psel    = psel_q;
    assign o_apb_penable = penable_q;

endmodule

// File: tb/tb_uart_apb_master.sv
module tb_uart_apb_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    uart_apb_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_apb_pclk   (clk),
        .i_apb_presetn(rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_write  (cmd_write),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_wdata  (cmd_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_rsp_timeout(rsp_timeout),
        .o_apb_paddr  (paddr),
        .o_apb_pwdata (pwdata),
        .o_apb_pwrite (pwrite),
        .o_apb_psel   (psel),
        .o_apb_penable(penable),
        .i_apb_pready (pready),
        .i_apb_prdata (prdata),
        .i_apb_pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Completer model configuration
    int          cfg_wait  = 0;
    logic [31:0] cfg_rdata = 32'h0;
    logic        cfg_err   = 1'b0;
    logic        cfg_stuck = 1'b0;
    int          acc_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Completer: answers after cfg_wait ACCESS cycles unless stuck.
    initial begin
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && penable) begin
                pready  = (acc_cnt == cfg_wait) && !cfg_stuck;
                prdata  = cfg_rdata;
                pslverr = pready & cfg_err;
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                acc_cnt = 0;
            end
        end
    end

    // Response monitor: pops one expectation per response handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                end
            end
        end
    end

    // Presents one command and returns #1 after the accepting edge (cycle N+1).
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic expect_rsp, input logic [31:0] e_rdata,
                         input logic e_err, input logic e_to);
        int guard;
        rsp_t e;
        guard = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        if (expect_rsp) begin
            e.rdata = e_rdata;
            e.err   = e_err;
            e.to    = e_to;
            sb.push_back(e);
        end
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_accept", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Cycle offset from the accepting edge at which rsp_valid is first seen.
    task automatic wait_rsp(output int lat, output int psel_seen);
        lat       = 0;
        psel_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (psel) psel_seen++;
        end while (!rsp_valid && lat < 300);
        chk("rsp_arrived", 64'(rsp_valid), 64'(1));
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_psel", 64'(psel), 64'(0));
        chk("rst_penable", 64'(penable), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        cfg_stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ps;
        int cnt;
        logic [31:0] held;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_psel", 64'(psel), 64'(0));
        chk("reset_penable", 64'(penable), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reset_paddr", 64'(paddr), 64'(0));
        chk("reset_pwdata", 64'(pwdata), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        chk("reset_rsp_timeout", 64'(rsp_timeout), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write with one wait state
        cfg_wait = 1;
        cfg_err  = 1'b0;
        issue(1'b1, 32'h0, 32'hA5, 1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("wr_n1_psel", 64'(psel), 64'(1));
        chk("wr_n1_penable", 64'(penable), 64'(0));
        chk("wr_pwdata", 64'(pwdata), 64'(32'hA5));
        chk("wr_pwrite", 64'(pwrite), 64'(1));
        @(negedge clk);
        chk("wr_n2_psel", 64'(psel), 64'(1));
        chk("wr_n2_penable", 64'(penable), 64'(1));
        @(negedge clk);
        chk("wr_n3_penable", 64'(penable), 64'(1));
        chk("wr_n3_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        chk("wr_n4_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("wr_n4_psel", 64'(psel), 64'(0));
        chk("wr_n4_penable", 64'(penable), 64'(0));
        chk("wr_paddr_hold", 64'(paddr), 64'(0));

        // Zero-wait read
        cfg_wait  = 0;
        cfg_rdata = 32'h1234_5678;
        issue(1'b0, 32'h4, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        wait_rsp(lat, ps);
        chk("rd_latency", 64'(lat), 64'(3));
        chk("rd_paddr", 64'(paddr), 64'(32'h4));

        // Read with slave error: data must be suppressed
        cfg_rdata = 32'hFFFF_FFFF;
        cfg_err   = 1'b1;
        issue(1'b0, 32'h8, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_rsp(lat, ps);
        chk("slverr_latency", 64'(lat), 64'(3));
        cfg_err = 1'b0;

        // Misaligned: local error, no bus activity
        issue(1'b0, 32'h2, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_rsp(lat, ps);
        chk("mis_latency", 64'(lat), 64'(1));
        chk("mis_psel_cycles", 64'(ps), 64'(0));
        chk("mis_paddr_unchanged", 64'(paddr), 64'(32'h8));

        // Response back-pressure with a second command waiting
        repeat (2) @(negedge clk);
        cfg_rdata = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue(1'b0, 32'hC, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
        wait_rsp(lat, ps);
        chk("bp_latency", 64'(lat), 64'(3));
        cfg_rdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h10;
        sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, to: 1'b0});
        held = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_rsp_rdata", 64'(rsp_rdata), 64'(32'hCAFE_0001));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        chk("bp_rdata_stable", 64'(rsp_rdata), 64'(held));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_accept_after_rsp", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(lat, ps);
        chk("bp_second_latency", 64'(lat), 64'(3));
        chk("bp_second_paddr", 64'(paddr), 64'(32'h10));

        // Completer that never answers
        repeat (2) @(negedge clk);
        cfg_stuck = 1'b1;
`ifdef UART_APB_MASTER_TIMEOUT_EN
        issue(1'b0, 32'h14, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        wait_rsp(lat, ps);
        chk("to_latency", 64'(lat), 64'(6));
        chk("to_psel", 64'(psel), 64'(0));
        chk("to_flag", 64'(rsp_timeout), 64'(1));
        repeat (2) @(negedge clk);
        issue(1'b0, 32'h18, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset_mid();
`else
        issue(1'b0, 32'h14, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (psel && penable && !rsp_valid) cnt++;
        end
        chk("stuck_psel_cycles", 64'(cnt), 64'(100));
        chk("stuck_timeout_flag", 64'(rsp_timeout), 64'(0));
        reset_mid();
`endif

        // Recovery after reset
        repeat (2) @(negedge clk);
        cfg_wait  = 2;
        cfg_rdata = 32'h5A5A_0F0F;
        issue(1'b0, 32'h20, 32'h0, 1'b1, 32'h5A5A_0F0F, 1'b0, 1'b0);
        wait_rsp(lat, ps);
        chk("recover_latency", 64'(lat), 64'(5));
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_apb_master.md
# uart_apb_master

APB3 initiator that converts single-beat command requests into APB3 transfers toward the UART register map (or any APB3 completer). It accepts one command at a time over a valid/ready interface. It drives the SETUP/ACCESS phases, waits out completer wait states and returns read data plus error status over a valid/ready response interface. It sits between a host-side agent (a debug bridge or test sequencer) and the UART APB3 slave port.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32, APB address width
- APB_DATA_WIDTH, 32, APB data width; multiple of 8
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; ≥1; used only with the timeout feature

Ports. One clock. Reset is asynchronous and active-low.
- i_apb_pclk  in  1  clock
- i_apb_presetn  in  1  async active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  APB_ADDR_WIDTH  byte address
- i_cmd_wdata  in  APB_DATA_WIDTH  write data
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed when high with o_rsp_valid
- o_rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes and errors
- o_rsp_err  out  1  pslverr, misalignment or timeout
- o_rsp_timeout  out  1  transfer aborted by timeout
- o_apb_paddr  out  APB_ADDR_WIDTH  APB address
- o_apb_pwdata  out  APB_DATA_WIDTH  APB write data
- o_apb_pwrite  out  1  APB direction
- o_apb_psel  out  1  APB select
- o_apb_penable  out  1  APB enable
- i_apb_pready  in  1  completer ready
- i_apb_prdata  in  APB_DATA_WIDTH  completer read data
- i_apb_pslverr  in  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_cmd_ready=1, derived combinationally from the state.
  - A handshake captures write, addr and wdata into registers.
  - Aligned address (addr[log2(APB_DATA_WIDTH/8)-1:0]==0): go to SETUP.
  - Misaligned address: go to RESP with err=1, rdata=0. No APB activity.
- SETUP: psel=1, penable=0, paddr/pwdata/pwrite driven from the captured registers. Lasts exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; all APB outputs held stable.
  - When i_apb_pready=1, capture rdata (prdata for reads, 0 for writes) and err=pslverr. If pslverr=1, rdata=0.
  - Then go to RESP.
- RESP:
  - o_rsp_valid=1, with rdata/err/timeout held stable.
  - On i_rsp_ready, go to IDLE.
  - o_cmd_ready is 0 here, so there is never more than one outstanding command.
- All APB and response outputs are registered.
- psel/penable deassert on the cycle after pready is sampled.
- o_apb_paddr, o_apb_pwdata and o_apb_pwrite hold their last values while idle.

## Timing
- Reset values:
  - All registered outputs are 0.
  - o_cmd_ready=1 after reset, since the FSM resets to IDLE.
- Zero-wait completer:
  - cmd handshake at cycle N; SETUP at N+1; ACCESS at N+2.
  - pready sampled at N+2; o_rsp_valid at N+3.
  - Earliest next cmd handshake is N+4, after rsp handshake at N+3.
- Each wait-state cycle extends ACCESS by one cycle.
- Misaligned command: o_rsp_valid at N+1.
- i_rsp_ready may be held high permanently; RESP then lasts one cycle.
- Reset mid-transfer:
  - psel, penable and rsp_valid drop immediately.
  - The FSM returns to IDLE.
  - The captured command is discarded with no response.
- i_apb_pready is ignored outside ACCESS.

## Configuration
- Macro: UART_APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, the next cycle deasserts psel/penable and enters RESP with err=1, timeout=1, rdata=0.
  - If pready=1 on the same cycle the count reaches TIMEOUT_CYCLES, the transfer completes normally.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - ACCESS waits indefinitely.
  - o_rsp_timeout is tied to 0.
  - No counter logic is present.

## Test plan
- Write addr 0x0, wdata 0xA5, completer pready one cycle after penable -> psel N+1..N+3, penable N+2..N+3, pwdata=0xA5; rsp_valid at N+4, err=0, rdata=0.
- Read addr 0x4, zero-wait completer returns 0x1234_5678 -> rsp_valid at N+3, rdata=0x12345678, err=0.
- Read with pslverr=1, prdata=0xFFFF_FFFF -> err=1, rdata=0.
- Command to addr 0x2 -> no psel assertion, rsp_valid at N+1, err=1.
- With UART_APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> psel drops after ACCESS times out, rsp err=1, timeout=1. Without the macro, psel stays high for 100 cycles and no response appears.
- Hold i_rsp_ready=0 for 5 cycles, assert i_cmd_valid throughout -> rsp fields stable and o_cmd_ready=0 until the rsp handshake; the second command is accepted the cycle after.
